vga_timing_rx: RTL and testbench
================================

# vga_timing_rx

Receive-side VGA timing recovery block: it samples an incoming HS/VS/RGB444 stream (the signals driven onto the Basys3 VGA pins) in the pixel clock domain and regenerates pixel coordinates, data-enable and start-of-frame. It also measures line and frame periods and reports lock against the nominal 1024x768@60 timing. It sits in loopback and self-check designs beside the display pipeline, and at the capture end of a second board receiving our VGA output.

## Interface
Parameters:
- H_ACTIVE, 1024, active pixels per line
- H_SYNC, 136, HS pulse width in clocks
- H_BP, 160, horizontal back porch in clocks
- H_TOTAL, 1344, clocks per line
- V_ACTIVE, 768, active lines per frame
- V_SYNC, 6, VS pulse width in lines
- V_BP, 29, vertical back porch in lines
- V_TOTAL, 806, lines per frame
- SYNC_POL, 0, active level of HS and VS (0 = active-low)

Ports:
- clk  in  1  pixel clock (65 MHz)
- rst_n  in  1  asynchronous, active-low reset
- hs_in  in  1  horizontal sync
- vs_in  in  1  vertical sync
- rgb_in  in  12  {r[3:0], g[3:0], b[3:0]}
- x_out  out  11  pixel column, 0..H_ACTIVE-1
- y_out  out  10  pixel row, 0..V_ACTIVE-1
- de_out  out  1  active pixel valid
- rgb_out  out  12  pixel data, forced 0 when de_out=0
- sof  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  timing matches parameters
- h_period  out  12  last measured line length in clocks
- v_period  out  11  last measured frame length in lines
- err  out  1  one-cycle pulse on loss of lock

## Operation
- Stage 1 registers hs_in, vs_in and rgb_in. All decoding uses stage-1 values.
- HS leading edge (hl): stage-1 HS at its active level with the previous stage-1 HS inactive.
- hcnt (12 b):
  - on hl: h_period <= hcnt+1, hcnt <= 0
  - otherwise increments, saturating at 4095
- VS is sampled only on hl.
- Frame start (fs): hl with VS active, where VS was inactive at the previous hl.
- vcnt (11 b):
  - on fs: v_period <= vcnt+1, vcnt <= 0
  - on any other hl: increments, saturating at 2047
- Per-frame sticky flag line_bad: set on any hl with hcnt+1 != H_TOTAL; cleared on fs after evaluation.
- Good frame: at fs, line_bad=0 and vcnt+1 == V_TOTAL.
- Lock FSM:
  - SEARCH: on the first fs -> CHECK with good_cnt=0.
  - CHECK: at fs, a good frame increments good_cnt, a bad frame clears it. good_cnt reaching 2 -> LOCKED.
  - LOCKED: any hl with a bad period, any bad frame at fs, hcnt reaching 2*H_TOTAL, or vcnt reaching 2*V_TOTAL -> SEARCH with a one-cycle err pulse.
- locked = 1 only in LOCKED.
- Active window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - x = hcnt-(H_SYNC+H_BP)
  - y = vcnt-(V_SYNC+V_BP)
- Stage 2 registers the outputs:
  - de_out = window AND locked
  - x_out, y_out, rgb_out carry values when de_out=1; otherwise all 0
  - sof = de_out with x=0, y=0
- Simultaneous hl and loss condition: the loss is reported (err) and the measurement still updates.
- Reset (async assert, sync release): all outputs 0, FSM in SEARCH, all counters and flags 0, stage-1 HS/VS at their inactive level.

## Timing
- Latency is 2 clk from the input pins to de_out, x_out, y_out, rgb_out and sof.
- An input pixel sampled 296 clocks after the hs_in leading edge appears as x_out=0.
- h_period updates 1 clk after hl is detected in stage 1, i.e. 2 clk after the hs_in edge.
- v_period updates on the same cycle as h_period at fs.
- locked rises 1 clk after the third fs of a clean stream, i.e. after 2 good frames.
- err is a single-cycle pulse; locked falls on the same cycle.
- Mid-frame reset: outputs drop to 0 immediately; relock requires 3 further fs.

## Test plan
- Clean XGA stream, 4 frames:
  - locked=1 after the third fs
  - de_out asserted for exactly 1024x768 cycles per frame
  - h_period=1344, v_period=806
- Pixel mapping: rgb_in = {x[3:0], y[3:0], 4'hA} driven at the source:
  - rgb_out matches at every x_out/y_out
  - sof coincides with (0,0), 2 clk after input
- One line of 1343 clocks in LOCKED:
  - err pulse on the next hl, locked=0, h_period=1343
  - relock after 3 fs
- hs_in held inactive while LOCKED:
  - err when hcnt reaches 2688
  - h_period unchanged until HS resumes
- Frame of 805 lines in CHECK:
  - good_cnt cleared, locked stays 0
  - locked only after 2 subsequent good frames
- rst_n low for 3 clk mid-frame:
  - all outputs 0 within the same cycle
  - recovery with locked=1 after 3 fs, err not asserted

Source files
------------

// File: rtl/vga_timing_rx.sv
// Recovers x/y/de/sof from a sampled HS/VS/RGB444 stream and reports lock against the nominal mode.
// Two clocks from pins to pixel outputs; no backpressure, one sample is consumed on every clock.
module vga_timing_rx #(
   parameter int H_ACTIVE = 1024,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int H_TOTAL  = 1344,
   parameter int V_ACTIVE = 768,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter int V_TOTAL  = 806,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic [11:0] rgb_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        de_out,
   output logic [11:0] rgb_out,
   output logic        sof,
   output logic        locked,
   output logic [11:0] h_period,
   output logic [10:0] v_period,
   output logic        err
);

   localparam logic [11:0] H_TOT   = 12'(H_TOTAL);
   localparam logic [11:0] H_START = 12'(H_SYNC + H_BP);
   localparam logic [11:0] H_END   = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [11:0] H_LOSS  = 12'(2 * H_TOTAL);
   localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
   localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
   localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [10:0] V_LOSS  = 11'(2 * V_TOTAL);

   typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

   // Reset asserts asynchronously and releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       arst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign arst_n = rst_sync_q[1];

   logic        hs_q, vs_q, hs_prev_q, vs_hl_q;
   logic [11:0] rgb_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         hs_q      <= ~SYNC_POL;
         vs_q      <= ~SYNC_POL;
         hs_prev_q <= ~SYNC_POL;
         rgb_q     <= '0;
      end else begin
         hs_q      <= hs_in;
         vs_q      <= vs_in;
         hs_prev_q <= hs_q;
         rgb_q     <= rgb_in;
      end
   end

   logic        hs_act, hs_prev_act, vs_act, hl, fs;
   logic [11:0] hcnt_q, hcnt_d, hcnt_inc;
   logic [10:0] vcnt_q, vcnt_d, vcnt_inc;
   logic        line_bad_q, h_bad, frame_good, loss;

   assign hs_act      = (hs_q == SYNC_POL);
   assign hs_prev_act = (hs_prev_q == SYNC_POL);
   assign vs_act      = (vs_q == SYNC_POL);
   assign hl          = hs_act && !hs_prev_act;
   assign fs          = hl && vs_act && !vs_hl_q;

   assign hcnt_inc   = hcnt_q + 12'd1;
   assign vcnt_inc   = vcnt_q + 11'd1;
   assign h_bad      = hl && (hcnt_inc != H_TOT);
   // The line closed by the frame-start edge still belongs to the frame being judged.
   assign frame_good = !line_bad_q && !h_bad && (vcnt_inc == V_TOT);

   // hcnt_d/vcnt_d are the coordinates of the pixel currently held in stage 1.
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (hl)                   hcnt_d = '0;
      else if (hcnt_q != '1)    hcnt_d = hcnt_inc;
      if (fs)                   vcnt_d = '0;
      else if (hl && vcnt_q != '1) vcnt_d = vcnt_inc;
   end

   assign loss = h_bad || (fs && !frame_good) || (hcnt_d == H_LOSS) || (vcnt_d == V_LOSS);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         vs_hl_q    <= 1'b0;
         line_bad_q <= 1'b0;
         h_period   <= '0;
         v_period   <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         if (hl) begin
            h_period <= hcnt_inc;
            vs_hl_q  <= vs_act;
         end
         if (fs)         v_period <= vcnt_inc;
         if (fs)         line_bad_q <= 1'b0;
         else if (h_bad) line_bad_q <= 1'b1;
      end
   end

   state_t     state_q;
   logic [1:0] good_cnt_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= S_SEARCH;
         good_cnt_q <= '0;
         locked     <= 1'b0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state_q)
            S_SEARCH: begin
               if (fs) begin
                  state_q    <= S_CHECK;
                  good_cnt_q <= '0;
               end
            end
            S_CHECK: begin
               if (fs) begin
                  if (!frame_good) begin
                     good_cnt_q <= '0;
                  end else begin
                     good_cnt_q <= good_cnt_q + 2'd1;
                     if (good_cnt_q == 2'd1) begin
                        state_q <= S_LOCKED;
                        locked  <= 1'b1;
                     end
                  end
               end
            end
            S_LOCKED: begin
               if (loss) begin
                  state_q <= S_SEARCH;
                  locked  <= 1'b0;
                  err     <= 1'b1;
               end
            end
            default: begin
               state_q <= S_SEARCH;
               locked  <= 1'b0;
            end
         endcase
      end
   end

   logic        win, de_d;
   logic [10:0] x_d;
   logic [9:0]  y_d;

   assign win  = (hcnt_d >= H_START) && (hcnt_d <= H_END) &&
                 (vcnt_d >= V_START) && (vcnt_d <= V_END);
   assign de_d = win && locked;
   assign x_d  = 11'(hcnt_d - H_START);
   assign y_d  = 10'(vcnt_d - V_START);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         de_out  <= 1'b0;
         x_out   <= '0;
         y_out   <= '0;
         rgb_out <= '0;
         sof     <= 1'b0;
      end else begin
         de_out  <= de_d;
         x_out   <= de_d ? x_d : '0;
         y_out   <= de_d ? y_d : '0;
         rgb_out <= de_d ? rgb_q : '0;
         sof     <= de_d && (x_d == '0) && (y_d == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a reduced video mode; a scoreboard queue holds the pixels
// the stimulus expects to be shown, and a negedge monitor retires them.
module tb_vga_timing_rx;

   localparam int HA = 16, HS = 4, HB = 6, HT = 32;
   localparam int VA = 8,  VS = 2, VB = 3, VT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        hs_in = 1'b1;
   logic        vs_in = 1'b1;
   logic [11:0] rgb_in = '0;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        de_out;
   logic [11:0] rgb_out;
   logic        sof;
   logic        locked;
   logic [11:0] h_period;
   logic [10:0] v_period;
   logic        err;

   vga_timing_rx #(
      .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
      .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in), .rgb_in(rgb_in),
      .x_out(x_out), .y_out(y_out), .de_out(de_out), .rgb_out(rgb_out), .sof(sof),
      .locked(locked), .h_period(h_period), .v_period(v_period), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic [11:0] rgb;
      int          t;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          err_cnt = 0;
   logic [11:0] err_hper = '0;
   logic        err_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (de_out) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_de: got pixel x=%0d y=%0d, expected none", x_out, y_out);
         end else begin
            mon_e = sb.pop_front();
            chk("x_out", 64'(x_out), 64'(mon_e.x));
            chk("y_out", 64'(y_out), 64'(mon_e.y));
            chk("rgb_out", 64'(rgb_out), 64'(mon_e.rgb));
            chk("sof", 64'(sof), 64'((mon_e.x == 0) && (mon_e.y == 0)));
            chk("latency", 64'(cyc - mon_e.t), 64'd2);
         end
      end else begin
         chk("blank_zero", 64'({x_out, y_out, rgb_out, sof}), 64'd0);
      end
      if (err) begin
         err_cnt++;
         err_hper = h_period;
         chk("locked_at_err", 64'(locked), 64'd0);
         chk("err_single", 64'(err_prev), 64'd0);
      end
      err_prev = err;
   end

   task automatic drive(input logic h, input logic v, input logic [11:0] c);
      hs_in  = h;
      vs_in  = v;
      rgb_in = c;
      @(posedge clk);
      #1;
   endtask

   // One source frame: optional short line, display cut-off line and mid-frame reset line.
   task automatic send_frame(input int nlines, input int short_line, input int disp_upto,
                             input int rst_line);
      int          len;
      logic [10:0] px;
      logic [9:0]  py;
      logic [11:0] c;
      exp_t        e;
      for (int v = 0; v < nlines; v++) begin
         len = (v == short_line) ? HT - 1 : HT;
         for (int h = 0; h < len; h++) begin
            if (v == rst_line && h == 0) begin
               rst_n = 1'b0;
               #1;
               chk("rst_pix", 64'({de_out, sof, x_out, y_out, rgb_out}), 64'd0);
               chk("rst_status", 64'({locked, err}), 64'd0);
               chk("rst_periods", 64'({h_period, v_period}), 64'd0);
            end
            if (v == rst_line && h == 3) rst_n = 1'b1;
            c = 12'hFFF;
            if (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) begin
               px = 11'(h - (HS + HB));
               py = 10'(v - (VS + VB));
               c  = {px[3:0], py[3:0], 4'hA};
               if (v <= disp_upto) begin
                  e.x = px; e.y = py; e.rgb = c; e.t = cyc;
                  sb.push_back(e);
               end
            end
            drive((h < HS) ? 1'b0 : 1'b1, (v < VS) ? 1'b0 : 1'b1, c);
         end
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pix", 64'({de_out, sof, x_out, y_out, rgb_out}), 64'd0);
      chk("reset_status", 64'({locked, err}), 64'd0);
      chk("reset_periods", 64'({h_period, v_period}), 64'd0);
      rst_n = 1'b1;
      repeat (5) drive(1'b1, 1'b1, 12'h000);

      // Clean stream: lock after the third frame start.
      send_frame(VT, -1, -1, -1);
      send_frame(VT, -1, -1, -1);
      chk("clean_locked_pre", 64'(locked), 64'd0);
      send_frame(VT, -1, 99, -1);
      chk("clean_locked", 64'(locked), 64'd1);
      chk("clean_sb_f2", 64'(sb.size()), 64'd0);
      send_frame(VT, -1, 99, -1);
      chk("clean_h_period", 64'(h_period), 64'd32);
      chk("clean_v_period", 64'(v_period), 64'd16);
      chk("clean_sb_f3", 64'(sb.size()), 64'd0);
      chk("clean_no_err", 64'(err_cnt), 64'd0);

      // Short line while locked.
      send_frame(VT, 7, 7, -1);
      chk("short_err_cnt", 64'(err_cnt), 64'd1);
      chk("short_h_period", 64'(err_hper), 64'd31);
      chk("short_unlocked", 64'(locked), 64'd0);
      chk("short_sb", 64'(sb.size()), 64'd0);
      send_frame(VT, -1, -1, -1);
      send_frame(VT, -1, -1, -1);
      chk("short_relock_pre", 64'(locked), 64'd0);
      send_frame(VT, -1, 99, -1);
      chk("short_relock", 64'(locked), 64'd1);
      chk("short_relock_sb", 64'(sb.size()), 64'd0);

      // HS stops while locked.
      repeat (100) drive(1'b1, 1'b1, 12'hFFF);
      chk("nohs_err_cnt", 64'(err_cnt), 64'd2);
      chk("nohs_h_at_err", 64'(err_hper), 64'd32);
      chk("nohs_h_period", 64'(h_period), 64'd32);
      chk("nohs_unlocked", 64'(locked), 64'd0);

      // Short frame while checking.
      send_frame(VT, -1, -1, -1);
      send_frame(VT - 1, -1, -1, -1);
      send_frame(VT, -1, -1, -1);
      chk("vshort_v_period", 64'(v_period), 64'd15);
      chk("vshort_locked_a", 64'(locked), 64'd0);
      send_frame(VT, -1, -1, -1);
      chk("vshort_locked_b", 64'(locked), 64'd0);
      send_frame(VT, -1, 99, -1);
      chk("vshort_relock", 64'(locked), 64'd1);
      chk("vshort_v_period2", 64'(v_period), 64'd16);
      chk("vshort_sb", 64'(sb.size()), 64'd0);

      // Reset pulse in the middle of a frame.
      send_frame(VT, -1, 7, 8);
      chk("mrst_unlocked", 64'(locked), 64'd0);
      chk("mrst_sb", 64'(sb.size()), 64'd0);
      send_frame(VT, -1, -1, -1);
      send_frame(VT, -1, -1, -1);
      chk("mrst_locked_pre", 64'(locked), 64'd0);
      send_frame(VT, -1, 99, -1);
      chk("mrst_relock", 64'(locked), 64'd1);
      chk("mrst_sb_final", 64'(sb.size()), 64'd0);
      chk("mrst_no_err", 64'(err_cnt), 64'd2);

      repeat (4) drive(1'b1, 1'b1, 12'h000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
